// File: rtl/dea_frame_sequencer_if.sv
// Bus bundle between the DEA frame sequencer, the UART byte handshakes and the
// three byte buffers (data, key, result).
interface dea_frame_sequencer_if #(
  parameter int ADDR_W = 7,
  parameter int KEY_W  = 2
);
  logic [7:0]        Rx_Data;
  logic              Rx_Ready;
  logic              Rx_Ack;
  logic              Tx_Busy;
  logic [7:0]        Tx_Data;
  logic              Tx_Send;
  logic [ADDR_W-1:0] Data_Addr;
  logic              Data_Wr;
  logic [7:0]        Data_RData;
  logic [KEY_W-1:0]  Key_Addr;
  logic              Key_Wr;
  logic [7:0]        Key_RData;
  logic [ADDR_W-1:0] Res_Addr;
  logic              Res_Wr;
  logic [7:0]        Res_WData;
  logic [7:0]        Res_RData;
  logic              Busy;
  logic              Done;
  logic              Error;
  logic [7:0]        Data_Len;

  modport master (
    input  Rx_Data, Rx_Ready, Tx_Busy, Data_RData, Key_RData, Res_RData,
    output Rx_Ack, Tx_Data, Tx_Send, Data_Addr, Data_Wr, Key_Addr, Key_Wr,
           Res_Addr, Res_Wr, Res_WData, Busy, Done, Error, Data_Len
  );

  modport slave (
    output Rx_Data, Rx_Ready, Tx_Busy, Data_RData, Key_RData, Res_RData,
    input  Rx_Ack, Tx_Data, Tx_Send, Data_Addr, Data_Wr, Key_Addr, Key_Wr,
           Res_Addr, Res_Wr, Res_WData, Busy, Done, Error, Data_Len
  );
endinterface

// File: rtl/dea_frame_sequencer.sv
// Frame controller for the DEA XOR datapath: receives length/data/key bytes,
// XORs data with a cyclic key into the result buffer and returns the frame.
module dea_frame_sequencer #(
  parameter int MAX_DATA = 100,
  parameter int MAX_KEY  = 3,
  parameter int ADDR_W   = 7,
  parameter int KEY_W    = 2
) (
  input logic                   Clk_100M,
  input logic                   Reset,
  dea_frame_sequencer_if.master bus
);

  localparam logic [7:0] MAX_DATA_B = 8'(MAX_DATA);
  localparam logic [7:0] MAX_KEY_B  = 8'(MAX_KEY);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    RX_DATA   = 4'd1,
    RX_KLEN   = 4'd2,
    RX_KEY    = 4'd3,
    ENC_INIT  = 4'd4,
    ENC_A     = 4'd5,
    ENC_B     = 4'd6,
    TXL_SEND  = 4'd7,
    TXL_HI    = 4'd8,
    TXL_LO    = 4'd9,
    TXD_FETCH = 4'd10,
    TXD_SEND  = 4'd11,
    TXD_HI    = 4'd12,
    TXD_LO    = 4'd13
  } state_t;

  state_t            state_r, stateNext_s;
  logic [7:0]        cnt_r, cnt_s;
  logic [7:0]        keyCnt_r, keyCnt_s;
  logic [7:0]        keyLen_r, keyLen_s;
  logic [7:0]        dataLen_r, dataLen_s;
  logic              rxAck_r, rxAck_s;
  logic              txSend_r, txSend_s;
  logic [7:0]        txData_r, txData_s;
  logic [ADDR_W-1:0] dataAddr_r, dataAddr_s;
  logic              dataWr_r, dataWr_s;
  logic [KEY_W-1:0]  keyAddr_r, keyAddr_s;
  logic              keyWr_r, keyWr_s;
  logic [ADDR_W-1:0] resAddr_r, resAddr_s;
  logic              resWr_r, resWr_s;
  logic [7:0]        resWData_r, resWData_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              error_r, error_s;

  logic              rxState_s;
  logic              take_s;
  logic [7:0]        cntInc_s;
  logic [7:0]        keyNext_s;
  logic              lastData_s;
  logic              lastKey_s;

  // Next-state, counter and output-register values for the frame FSM
  always_comb begin
    stateNext_s = state_r;
    cnt_s       = cnt_r;
    keyCnt_s    = keyCnt_r;
    keyLen_s    = keyLen_r;
    dataLen_s   = dataLen_r;
    txData_s    = txData_r;
    dataAddr_s  = dataAddr_r;
    keyAddr_s   = keyAddr_r;
    resAddr_s   = resAddr_r;
    resWData_s  = resWData_r;
    txSend_s    = 1'b0;
    dataWr_s    = 1'b0;
    keyWr_s     = 1'b0;
    resWr_s     = 1'b0;
    done_s      = 1'b0;
    error_s     = 1'b0;

    rxState_s  = (state_r == IDLE) || (state_r == RX_DATA) ||
                 (state_r == RX_KLEN) || (state_r == RX_KEY);
    take_s     = rxState_s && bus.Rx_Ready && !rxAck_r;
    cntInc_s   = cnt_r + 8'd1;
    lastData_s = (cnt_r == (dataLen_r - 8'd1));
    lastKey_s  = (keyCnt_r == (keyLen_r - 8'd1));
    keyNext_s  = lastKey_s ? 8'd0 : (keyCnt_r + 8'd1);

    // Ack rises with the byte it acknowledges and drops once Ready is gone
    if (take_s) begin
      rxAck_s = 1'b1;
    end else if (rxAck_r && !bus.Rx_Ready) begin
      rxAck_s = 1'b0;
    end else begin
      rxAck_s = rxAck_r;
    end

    case (state_r)
      IDLE: begin
        if (take_s) begin
          if ((bus.Rx_Data == 8'd0) || (bus.Rx_Data > MAX_DATA_B)) begin
            error_s = 1'b1;
          end else begin
            dataLen_s   = bus.Rx_Data;
            cnt_s       = 8'd0;
            stateNext_s = RX_DATA;
          end
        end else begin
          stateNext_s = IDLE;
        end
      end
      RX_DATA: begin
        if (take_s) begin
          dataAddr_s = cnt_r[ADDR_W-1:0];
          dataWr_s   = 1'b1;
          if (lastData_s) begin
            cnt_s       = 8'd0;
            stateNext_s = RX_KLEN;
          end else begin
            cnt_s = cntInc_s;
          end
        end else begin
          stateNext_s = RX_DATA;
        end
      end
      RX_KLEN: begin
        if (take_s) begin
          if ((bus.Rx_Data == 8'd0) || (bus.Rx_Data > MAX_KEY_B)) begin
            error_s     = 1'b1;
            stateNext_s = IDLE;
          end else begin
            keyLen_s    = bus.Rx_Data;
            keyCnt_s    = 8'd0;
            stateNext_s = RX_KEY;
          end
        end else begin
          stateNext_s = RX_KLEN;
        end
      end
      RX_KEY: begin
        if (take_s) begin
          keyAddr_s = keyCnt_r[KEY_W-1:0];
          keyWr_s   = 1'b1;
          if (lastKey_s) begin
            stateNext_s = ENC_INIT;
          end else begin
            keyCnt_s = keyCnt_r + 8'd1;
          end
        end else begin
          stateNext_s = RX_KEY;
        end
      end
      // One spare cycle lets the last key write land before the first read
      ENC_INIT: begin
        cnt_s       = 8'd0;
        keyCnt_s    = 8'd0;
        dataAddr_s  = {ADDR_W{1'b0}};
        keyAddr_s   = {KEY_W{1'b0}};
        stateNext_s = ENC_A;
      end
      ENC_A: begin
        stateNext_s = ENC_B;
      end
      ENC_B: begin
        resWr_s    = 1'b1;
        resAddr_s  = cnt_r[ADDR_W-1:0];
        resWData_s = bus.Data_RData ^ bus.Key_RData;
        if (lastData_s) begin
          stateNext_s = TXL_SEND;
        end else begin
          cnt_s       = cntInc_s;
          keyCnt_s    = keyNext_s;
          dataAddr_s  = cntInc_s[ADDR_W-1:0];
          keyAddr_s   = keyNext_s[KEY_W-1:0];
          stateNext_s = ENC_A;
        end
      end
      TXL_SEND: begin
        if (!bus.Tx_Busy) begin
          txSend_s    = 1'b1;
          txData_s    = dataLen_r;
          stateNext_s = TXL_HI;
        end else begin
          stateNext_s = TXL_SEND;
        end
      end
      TXL_HI: begin
        if (bus.Tx_Busy) begin
          stateNext_s = TXL_LO;
        end else begin
          stateNext_s = TXL_HI;
        end
      end
      TXL_LO: begin
        if (!bus.Tx_Busy) begin
          cnt_s       = 8'd0;
          resAddr_s   = {ADDR_W{1'b0}};
          stateNext_s = TXD_FETCH;
        end else begin
          stateNext_s = TXL_LO;
        end
      end
      TXD_FETCH: begin
        stateNext_s = TXD_SEND;
      end
      TXD_SEND: begin
        if (!bus.Tx_Busy) begin
          txSend_s    = 1'b1;
          txData_s    = bus.Res_RData;
          stateNext_s = TXD_HI;
        end else begin
          stateNext_s = TXD_SEND;
        end
      end
      TXD_HI: begin
        if (bus.Tx_Busy) begin
          stateNext_s = TXD_LO;
        end else begin
          stateNext_s = TXD_HI;
        end
      end
      TXD_LO: begin
        if (!bus.Tx_Busy) begin
          if (lastData_s) begin
            done_s      = 1'b1;
            stateNext_s = IDLE;
          end else begin
            cnt_s       = cntInc_s;
            resAddr_s   = cntInc_s[ADDR_W-1:0];
            stateNext_s = TXD_FETCH;
          end
        end else begin
          stateNext_s = TXD_LO;
        end
      end
      default: begin
        stateNext_s = IDLE;
      end
    endcase

    busy_s = (stateNext_s != IDLE);
  end

  // FSM state register
  always_ff @(posedge Clk_100M or posedge Reset) begin
    if (Reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // Counters and registered outputs
  always_ff @(posedge Clk_100M or posedge Reset) begin
    if (Reset) begin
      cnt_r      <= 8'd0;
      keyCnt_r   <= 8'd0;
      keyLen_r   <= 8'd0;
      dataLen_r  <= 8'd0;
      rxAck_r    <= 1'b0;
      txSend_r   <= 1'b0;
      txData_r   <= 8'd0;
      dataAddr_r <= {ADDR_W{1'b0}};
      dataWr_r   <= 1'b0;
      keyAddr_r  <= {KEY_W{1'b0}};
      keyWr_r    <= 1'b0;
      resAddr_r  <= {ADDR_W{1'b0}};
      resWr_r    <= 1'b0;
      resWData_r <= 8'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      cnt_r      <= cnt_s;
      keyCnt_r   <= keyCnt_s;
      keyLen_r   <= keyLen_s;
      dataLen_r  <= dataLen_s;
      rxAck_r    <= rxAck_s;
      txSend_r   <= txSend_s;
      txData_r   <= txData_s;
      dataAddr_r <= dataAddr_s;
      dataWr_r   <= dataWr_s;
      keyAddr_r  <= keyAddr_s;
      keyWr_r    <= keyWr_s;
      resAddr_r  <= resAddr_s;
      resWr_r    <= resWr_s;
      resWData_r <= resWData_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      error_r    <= error_s;
    end
  end

  assign bus.Rx_Ack    = rxAck_r;
  assign bus.Tx_Send   = txSend_r;
  assign bus.Tx_Data   = txData_r;
  assign bus.Data_Addr = dataAddr_r;
  assign bus.Data_Wr   = dataWr_r;
  assign bus.Key_Addr  = keyAddr_r;
  assign bus.Key_Wr    = keyWr_r;
  assign bus.Res_Addr  = resAddr_r;
  assign bus.Res_Wr    = resWr_r;
  assign bus.Res_WData = resWData_r;
  assign bus.Busy      = busy_r;
  assign bus.Done      = done_r;
  assign bus.Error     = error_r;
  assign bus.Data_Len  = dataLen_r;

endmodule

// File: tb/tb_dea_frame_sequencer.sv
// Scoreboard bench for dea_frame_sequencer: directed frames drive a UART-like
// receiver, buffer and sender models; a negedge monitor checks every output event.
module tb_dea_frame_sequencer;

  typedef logic [7:0] byte_q_t [$];
  typedef struct {
    int         kind;   // 0 = Tx byte, 1 = Done (val = Data_Len), 2 = Error
    logic [7:0] val;
  } ev_t;

  logic Clk;
  logic Reset;

  dea_frame_sequencer_if #(.ADDR_W(7), .KEY_W(2)) bus ();

  dea_frame_sequencer #(.MAX_DATA(100), .MAX_KEY(3), .ADDR_W(7), .KEY_W(2)) dut (
    .Clk_100M (Clk),
    .Reset    (Reset),
    .bus      (bus)
  );

  ev_t        q[$];
  int         nTests = 0;
  int         nFail  = 0;
  int         dataWrCnt = 0;
  int         keyWrCnt  = 0;
  int         ackRise   = 0;
  int         txCnt     = 0;
  logic       ackPrev   = 1'b0;
  logic       pendingRise = 1'b0;
  logic       longBusy  = 1'b0;
  logic [7:0] dataMem [128];
  logic [7:0] keyMem  [4];
  logic [7:0] resMem  [128];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Synchronous-read buffer models
  always @(posedge Clk) begin
    if (bus.Data_Wr) dataMem[bus.Data_Addr] <= bus.Rx_Data;
    if (bus.Key_Wr)  keyMem[bus.Key_Addr]   <= bus.Rx_Data;
    if (bus.Res_Wr)  resMem[bus.Res_Addr]   <= bus.Res_WData;
    bus.Data_RData <= dataMem[bus.Data_Addr];
    bus.Key_RData  <= keyMem[bus.Key_Addr];
    bus.Res_RData  <= resMem[bus.Res_Addr];
    if (bus.Data_Wr) dataWrCnt++;
    if (bus.Key_Wr)  keyWrCnt++;
    if (bus.Rx_Ack && !ackPrev) ackRise++;
    ackPrev = bus.Rx_Ack;
  end

  // Sender model: busy starts the cycle after a strobe
  initial begin
    bus.Tx_Busy = 1'b0;
    forever begin
      @(negedge Clk);
      if (bus.Tx_Send && !Reset) begin
        @(posedge Clk);
        #1 bus.Tx_Busy = 1'b1;
        repeat (longBusy ? 1000 : 3) @(posedge Clk);
        #1 bus.Tx_Busy = 1'b0;
        longBusy = 1'b0;
      end
    end
  end

  task automatic expectEv(input int kind, input logic [7:0] val, input string name);
    ev_t e;
    nTests++;
    if (q.size() == 0) begin
      nFail++;
      $display("FAIL %s: got unexpected event value %0h, expected no event", name, val);
    end else begin
      nTests--;
      e = q.pop_front();
      check(name, {kind[7:0], val}, {e.kind[7:0], e.val});
    end
  endtask

  // Monitor: every Tx strobe, Done and Error pulse is matched against the scoreboard
  always @(negedge Clk) begin
    if (!Reset) begin
      if (bus.Tx_Send) begin
        check("tx_strobe_gap", {bus.Tx_Busy, pendingRise}, 2'b00);
        expectEv(0, bus.Tx_Data, "tx_byte");
        txCnt++;
        pendingRise = 1'b1;
      end else if (bus.Tx_Busy) begin
        pendingRise = 1'b0;
      end
      if (bus.Done)  expectEv(1, bus.Data_Len, "done_len");
      if (bus.Error) expectEv(2, 8'h00, "error");
    end
  end

  task automatic pushEv(input int kind, input logic [7:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    q.push_back(e);
  endtask

  task automatic expectTx(input byte_q_t tx);
    foreach (tx[i]) pushEv(0, tx[i]);
    pushEv(1, tx[0]);
  endtask

  task automatic sendByte(input logic [7:0] b, input int hold);
    int c;
    bus.Rx_Data  = b;
    bus.Rx_Ready = 1'b1;
    c = 0;
    do begin @(posedge Clk); #1; c++; end while (!bus.Rx_Ack && c < 500);
    check("rx_ack_rise", bus.Rx_Ack, 1'b1);
    repeat (hold) @(posedge Clk);
    #1 bus.Rx_Ready = 1'b0;
    c = 0;
    do begin @(posedge Clk); #1; c++; end while (bus.Rx_Ack && c < 500);
    if (bus.Rx_Ack) check("rx_ack_fall", bus.Rx_Ack, 1'b0);
  endtask

  task automatic sendFrame(input byte_q_t fr, input int hold);
    foreach (fr[i]) sendByte(fr[i], hold);
  endtask

  task automatic waitIdle(input int limit);
    int c = 0;
    while ((q.size() != 0 || bus.Busy) && c < limit) begin
      @(posedge Clk); #1; c++;
    end
    check("drain", {q.size() == 0, !bus.Busy}, 2'b11);
    repeat (2) @(posedge Clk);
    #1;
  endtask

  function automatic logic [63:0] outVec();
    return {16'd0, bus.Rx_Ack, bus.Tx_Send, bus.Tx_Data, bus.Data_Addr, bus.Data_Wr,
            bus.Key_Addr, bus.Key_Wr, bus.Res_Addr, bus.Res_Wr, bus.Res_WData,
            bus.Busy, bus.Done, bus.Error, bus.Data_Len};
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", nTests);
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t fr, tx;
    int      d0, k0, a0, t0;

    Reset        = 1'b1;
    bus.Rx_Data  = 8'h00;
    bus.Rx_Ready = 1'b0;
    repeat (3) @(posedge Clk);
    #1 check("reset_outputs", outVec(), 64'd0);
    @(negedge Clk) Reset = 1'b0;
    repeat (2) @(posedge Clk);
    #1;

    // Basic frame: key wraps after two bytes
    tx = '{8'h03, 8'h61, 8'h43, 8'h63};
    expectTx(tx);
    fr = '{8'h03, 8'h41, 8'h42, 8'h43, 8'h02, 8'h20, 8'h01};
    sendFrame(fr, 0);
    waitIdle(2000);
    check("data_buf0", dataMem[0], 8'h41);
    check("data_buf1", dataMem[1], 8'h42);
    check("data_buf2", dataMem[2], 8'h43);
    check("key_buf0",  keyMem[0],  8'h20);
    check("key_buf1",  keyMem[1],  8'h01);
    check("res_buf0",  resMem[0],  8'h61);
    check("res_buf1",  resMem[1],  8'h43);
    check("res_buf2",  resMem[2],  8'h63);
    check("data_len",  bus.Data_Len, 8'h03);

    // Illegal data lengths
    d0 = dataWrCnt;
    pushEv(2, 8'h00);
    sendByte(8'h00, 0);
    waitIdle(200);
    pushEv(2, 8'h00);
    sendByte(8'h65, 0);
    waitIdle(200);
    check("err_no_data_wr", dataWrCnt - d0, 0);
    check("err_data_len_kept", bus.Data_Len, 8'h03);
    tx = '{8'h01, 8'hFF};
    expectTx(tx);
    fr = '{8'h01, 8'h7E, 8'h01, 8'h81};
    sendFrame(fr, 0);
    waitIdle(2000);

    // Illegal key length
    k0 = keyWrCnt;
    t0 = txCnt;
    pushEv(2, 8'h00);
    fr = '{8'h01, 8'hFF, 8'h04};
    sendFrame(fr, 0);
    waitIdle(200);
    check("klen_no_key_wr", keyWrCnt - k0, 0);
    check("klen_no_tx", txCnt - t0, 0);

    // Rx_Ready held for 50 cycles per byte
    d0 = dataWrCnt;
    k0 = keyWrCnt;
    a0 = ackRise;
    tx = '{8'h02, 8'h1F, 8'h2F};
    expectTx(tx);
    fr = '{8'h02, 8'h10, 8'h20, 8'h01, 8'h0F};
    sendFrame(fr, 50);
    waitIdle(2000);
    check("hold_data_wr", dataWrCnt - d0, 2);
    check("hold_key_wr",  keyWrCnt - k0,  1);
    check("hold_ack_rise", ackRise - a0,  5);

    // Sender stalls 1000 cycles after the length byte
    longBusy = 1'b1;
    tx = '{8'h04, 8'h11, 8'h22, 8'h33, 8'h14};
    expectTx(tx);
    fr = '{8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h03, 8'h10, 8'h20, 8'h30};
    sendFrame(fr, 0);
    waitIdle(4000);

    // Largest frame: 100 data bytes, 1 key byte
    tx = '{8'h64};
    fr = '{8'h64};
    for (int i = 0; i < 100; i++) begin
      fr.push_back(8'(i));
      tx.push_back(8'(i) ^ 8'h5A);
    end
    fr.push_back(8'h01);
    fr.push_back(8'h5A);
    expectTx(tx);
    sendFrame(fr, 0);
    waitIdle(5000);
    check("res_buf99", resMem[99], 8'h39);
    check("data_len_max", bus.Data_Len, 8'h64);

    // Reset in the middle of RX_DATA
    fr = '{8'h05, 8'h01, 8'h02};
    sendFrame(fr, 0);
    check("busy_mid_frame", bus.Busy, 1'b1);
    #2 Reset = 1'b1;
    #1 check("async_reset_outputs", outVec(), 64'd0);
    repeat (2) @(posedge Clk);
    @(negedge Clk) Reset = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    tx = '{8'h02, 8'h55, 8'hAA};
    expectTx(tx);
    fr = '{8'h02, 8'hAA, 8'h55, 8'h01, 8'hFF};
    sendFrame(fr, 0);
    waitIdle(2000);
    check("post_reset_len", bus.Data_Len, 8'h02);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/dea_frame_sequencer.md
Name: dea_frame_sequencer

Overview:
Frame-level controller for the DEA XOR-encryption datapath. It parses the UART frame (data length, data bytes, key length, key bytes) from the UART receiver handshake and writes the bytes into external data and key buffers. It then sequences the XOR of each data byte with a cyclically repeated key into the result buffer, and returns the frame (length byte, then result bytes) through the UART sender handshake. It sits between UART_Receiver/UART_Sender and the three byte buffers. It replaces ad-hoc index/flag sequencing with one explicit FSM.

Parameters:
MAX_DATA, 100, largest accepted data length in bytes (1..MAX_DATA valid)
MAX_KEY, 3, largest accepted key length in bytes (1..MAX_KEY valid)
ADDR_W, 7, data/result buffer address width (2**ADDR_W >= MAX_DATA)
KEY_W, 2, key buffer address width (2**KEY_W >= MAX_KEY)

Ports:
Clk_100M  in  1  system clock
Reset  in  1  asynchronous, active-high reset
Rx_Data  in  8  received byte, valid while Rx_Ready high
Rx_Ready  in  1  receiver has a byte
Rx_Ack  out  1  byte consumed
Tx_Busy  in  1  sender shifting a byte
Tx_Data  out  8  byte to send
Tx_Send  out  1  one-cycle send strobe
Data_Addr  out  ADDR_W  data buffer address (write in RX_DATA, read in ENC)
Data_Wr  out  1  data buffer write enable, write data = Rx_Data
Data_RData  in  8  data buffer read data, 1-cycle synchronous latency
Key_Addr  out  KEY_W  key buffer address
Key_Wr  out  1  key buffer write enable, write data = Rx_Data
Key_RData  in  8  key buffer read data, 1-cycle latency
Res_Addr  out  ADDR_W  result buffer address
Res_Wr  out  1  result buffer write enable
Res_WData  out  8  result write data
Res_RData  in  8  result buffer read data, 1-cycle latency
Busy  out  1  high in every state except IDLE
Done  out  1  one-cycle pulse after the last Tx byte is accepted
Error  out  1  one-cycle pulse on an illegal length byte
Data_Len  out  8  latched data length of the last accepted frame (drives LED index wrap)

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0, including Rx_Ack, Tx_Send, all *_Wr strobes, addresses, Data_Len, Done and Error. Internal counters 0. A reset mid-frame abandons the frame; buffer contents are left untouched.
- Rx handshake: a byte is taken only when Rx_Ready=1 and Rx_Ack=0. In that cycle the block registers the byte, asserts the buffer write if applicable, and sets Rx_Ack=1. Rx_Ack holds until Rx_Ready=0, then clears the next cycle. Exactly one byte is taken per Rx_Ready pulse, however long it is held.
- FSM states and transitions:
  - IDLE: takes a byte as the data length L.
    - L=0 or L>MAX_DATA: Error pulse, stay in IDLE.
    - Otherwise: latch L into Data_Len, go to RX_DATA.
  - RX_DATA: byte i (i = 0..L-1) gives Data_Addr=i, Data_Wr=1. After i=L-1, go to RX_KLEN.
  - RX_KLEN: takes key length K.
    - K=0 or K>MAX_KEY: Error pulse, go to IDLE.
    - Otherwise: go to RX_KEY.
  - RX_KEY: byte j (j = 0..K-1) gives Key_Addr=j, Key_Wr=1. After j=K-1, go to ENC.
  - ENC: two cycles per byte.
    - Cycle A: Data_Addr=i, Key_Addr=k.
    - Cycle B: Res_Addr=i, Res_WData=Data_RData^Key_RData, Res_Wr=1.
    - After each byte, k wraps to 0 when k=K-1. After i=L-1 write, go to TX_LEN.
    - ENC latency is 2L cycles.
  - TX_LEN: when Tx_Busy=0, drives Tx_Data=L and Tx_Send=1 for one cycle.
    - It then waits for Tx_Busy=1, then Tx_Busy=0, then goes to TX_DATA.
  - TX_DATA: for byte n, presents Res_Addr=n one cycle before it is needed.
    - Sends Res_RData with the same strobe/wait rule as TX_LEN.
    - After byte L-1 completes (Tx_Busy falls), Done pulse, go to IDLE.
- Tx_Send is never reasserted while Tx_Busy=1 or before Tx_Busy has risen for the previous strobe.
- Rx bytes arriving in ENC/TX states are not acknowledged; Rx_Ack stays 0 and the receiver holds them.
- Counters are 8-bit. Address outputs are the counter's low ADDR_W/KEY_W bits. L=MAX_DATA addresses 0..MAX_DATA-1 with no overflow.
- Rx_Ready=1 on the same edge as a state change: the byte is taken by the state entered only after Rx_Ack cycles low.

Test Plan:
- Frame 03 41 42 43 02 20 01 -> data buffer 41 42 43; key buffer 20 01; result 61 43 63; Tx sequence 03 61 43 63; Done pulse once; Data_Len=03.
- Length byte 00, then length byte 0x65 (101) -> Error pulse each time, state stays IDLE, no Data_Wr; a following valid frame processes normally.
- Frame 01 FF 04 ... (K=4 > MAX_KEY) -> Error pulse after key length byte, return to IDLE, no Key_Wr, no Tx.
- Rx_Ready held high 50 cycles per byte -> exactly one write per byte and one Rx_Ack rise per byte.
- Tx_Busy forced high for 1000 cycles after the first strobe -> no further Tx_Send until Tx_Busy falls; the sequence completes afterwards intact.
- Reset asserted mid-RX_DATA (after 2 of 5 bytes) -> all outputs 0 immediately (async); the next frame 02 AA 55 01 FF yields Tx 02 55 AA.
